// File: rtl/dht_read_ctrl_060_pkg.sv
// Shared definitions for the single-wire temperature/humidity reader: FSM encodings,
// 40-bit frame field layout and the binary-to-BCD helper used for the display digits.
package dht_060_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_START_LOW = 4'd1;
    localparam logic [3:0] ST_REL_WAIT  = 4'd2;
    localparam logic [3:0] ST_RESP_LO   = 4'd3;
    localparam logic [3:0] ST_RESP_HI   = 4'd4;
    localparam logic [3:0] ST_BIT_LO    = 4'd5;
    localparam logic [3:0] ST_BIT_HI    = 4'd6;
    localparam logic [3:0] ST_CHECK     = 4'd7;
    localparam logic [3:0] ST_DONE      = 4'd8;
    localparam logic [3:0] ST_ERR       = 4'd9;

    // Frame arrives MSB first as {hum_i, hum_d, tem_i, tem_d, sum}
    localparam int FRAME_W   = 40;
    localparam int HUM_I_LSB = 32;
    localparam int HUM_D_LSB = 24;
    localparam int TEM_I_LSB = 16;
    localparam int TEM_D_LSB = 8;
    localparam int SUM_LSB   = 0;
    localparam logic [5:0] LAST_BIT_IDX = 6'(FRAME_W - 1);

    // Two-digit BCD {tens, ones}; anything above 99 cannot be shown and saturates to 99
    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        if (v > 8'd99) begin
            return 8'h99;
        end
        tens = 4'(v / 8'd10);
        ones = 4'(v % 8'd10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/dht_read_ctrl_060_tick_gen.sv
// Microsecond and millisecond strobes derived from the system clock. Both prescalers can be
// restarted so that timing windows line up exactly with the start of a transaction.
module tick_gen_060 #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic us_tick,
    output logic ms_tick
);
    localparam int unsigned US_DIV = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;

    logic [31:0] us_cnt;
    logic [9:0]  ms_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            us_cnt  <= '0;
            us_tick <= 1'b0;
        end else if (clr) begin
            us_cnt  <= '0;
            us_tick <= 1'b0;
        end else if (us_cnt == US_DIV - 1) begin
            us_cnt  <= '0;
            us_tick <= 1'b1;
        end else begin
            us_cnt  <= us_cnt + 32'd1;
            us_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ms_cnt  <= '0;
            ms_tick <= 1'b0;
        end else if (clr) begin
            ms_cnt  <= '0;
            ms_tick <= 1'b0;
        end else if (us_tick && ms_cnt == 10'd999) begin
            ms_cnt  <= '0;
            ms_tick <= 1'b1;
        end else begin
            if (us_tick) begin
                ms_cnt <= ms_cnt + 10'd1;
            end
            ms_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/dht_read_ctrl_060.sv
// Single-wire temperature/humidity sensor sequencer: start pulse, response timing, 40-bit
// frame capture, checksum check and BCD digits for the 7-segment scanner.
module dht_read_ctrl_060
    import dht_060_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = 100_000_000,
    parameter int unsigned POLL_MS       = 2000,
    parameter int unsigned START_LOW_MS  = 18,
    parameter int unsigned TIMEOUT_US    = 200,
    parameter int unsigned BIT_THRESH_US = 50
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_start,
    inout  wire         I_O_sda,
    output logic        O_busy,
    output logic        O_valid,
    output logic        O_err,
    output logic [39:0] O_raw,
    output logic [3:0]  O_num1,
    output logic [3:0]  O_num2,
    output logic [3:0]  O_num3,
    output logic [3:0]  O_num4,
    output logic [3:0]  O_num5,
    output logic [3:0]  O_num6,
    output logic [3:0]  O_num7,
    output logic [3:0]  O_num8
);
    localparam int unsigned START_LOW_US = START_LOW_MS * 1000;

    logic [3:0]  state;
    logic [3:0]  state_next;
    logic        us_tick;
    logic        ms_tick;
    logic        start_req;
    logic        poll_due;
    logic        drv_low;
    logic        sda_meta;
    logic        sda_sync;
    logic        sda_prev;
    logic        sda_rise;
    logic        sda_fall;
    logic [31:0] tick_cnt;
    logic [31:0] poll_cnt;
    logic [5:0]  bit_idx;
    logic [39:0] shift_reg;
    logic        timeout_hit;
    logic        low_done;
    logic        bit_val;
    logic [7:0]  sum_calc;
    logic        sum_ok;

    assign I_O_sda = drv_low ? 1'b0 : 1'bz;

    tick_gen_060 #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick_gen (
        .clk    (I_clk),
        .rst    (I_rst),
        .clr    (start_req),
        .us_tick(us_tick),
        .ms_tick(ms_tick)
    );

    // The line idles high through the pull-up, so the synchronizer resets to 1
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            sda_meta <= I_O_sda;
            sda_sync <= sda_meta;
            sda_prev <= sda_sync;
        end
    end

    assign sda_rise    = sda_sync & ~sda_prev;
    assign sda_fall    = ~sda_sync & sda_prev;
    assign poll_due    = (POLL_MS != 0) && (poll_cnt >= POLL_MS);
    assign start_req   = (state == ST_IDLE) && (I_start || poll_due);
    assign timeout_hit = us_tick && (tick_cnt == TIMEOUT_US - 1);
    assign low_done    = us_tick && (tick_cnt == START_LOW_US - 1);
    assign bit_val     = (tick_cnt > BIT_THRESH_US);
    assign sum_calc    = shift_reg[HUM_I_LSB +: 8] + shift_reg[HUM_D_LSB +: 8]
                       + shift_reg[TEM_I_LSB +: 8] + shift_reg[TEM_D_LSB +: 8];
    assign sum_ok      = (sum_calc == shift_reg[SUM_LSB +: 8]);

    // REL_WAIT waits for a falling edge rather than a low level: our own start pulse is
    // still draining out of the synchronizer when the line is released
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (start_req) state_next = ST_START_LOW;
            ST_START_LOW: if (low_done) state_next = ST_REL_WAIT;
            ST_REL_WAIT:  if (sda_fall) state_next = ST_RESP_LO;
                          else if (timeout_hit) state_next = ST_ERR;
            ST_RESP_LO:   if (sda_rise) state_next = ST_RESP_HI;
                          else if (timeout_hit) state_next = ST_ERR;
            ST_RESP_HI:   if (sda_fall) state_next = ST_BIT_LO;
                          else if (timeout_hit) state_next = ST_ERR;
            ST_BIT_LO:    if (sda_rise) state_next = ST_BIT_HI;
                          else if (timeout_hit) state_next = ST_ERR;
            ST_BIT_HI:    if (sda_fall) state_next = (bit_idx == LAST_BIT_IDX) ? ST_CHECK : ST_BIT_LO;
                          else if (timeout_hit) state_next = ST_ERR;
            ST_CHECK:     state_next = sum_ok ? ST_DONE : ST_ERR;
            ST_DONE:      state_next = ST_IDLE;
            ST_ERR:       state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state     <= ST_IDLE;
            drv_low   <= 1'b0;
            O_busy    <= 1'b0;
            O_valid   <= 1'b0;
            O_err     <= 1'b0;
            tick_cnt  <= '0;
            poll_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state   <= state_next;
            drv_low <= (state_next == ST_START_LOW);
            O_busy  <= !(state_next inside {ST_IDLE, ST_DONE, ST_ERR});
            O_valid <= (state_next == ST_DONE);
            O_err   <= (state_next == ST_ERR);

            if (state_next != state) begin
                tick_cnt <= '0;
            end else if (us_tick) begin
                tick_cnt <= tick_cnt + 32'd1;
            end

            if (start_req) begin
                poll_cnt <= '0;
            end else if (ms_tick && !poll_due && POLL_MS != 0) begin
                poll_cnt <= poll_cnt + 32'd1;
            end

            if (start_req) begin
                bit_idx   <= '0;
                shift_reg <= '0;
            end else if (state == ST_BIT_HI && sda_fall) begin
                bit_idx   <= bit_idx + 6'd1;
                shift_reg <= {shift_reg[FRAME_W-2:0], bit_val};
            end
        end
    end

    // Published values change only on a verified frame, in the same cycle O_valid rises
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_raw  <= '0;
            O_num1 <= '0;
            O_num2 <= '0;
            O_num3 <= '0;
            O_num4 <= '0;
            O_num5 <= '0;
            O_num6 <= '0;
            O_num7 <= '0;
            O_num8 <= '0;
        end else if (state_next == ST_DONE) begin
            O_raw            <= shift_reg;
            {O_num1, O_num2} <= to_bcd(shift_reg[HUM_I_LSB +: 8]);
            {O_num3, O_num4} <= to_bcd(shift_reg[HUM_D_LSB +: 8]);
            {O_num5, O_num6} <= to_bcd(shift_reg[TEM_I_LSB +: 8]);
            {O_num7, O_num8} <= to_bcd(shift_reg[TEM_D_LSB +: 8]);
        end
    end

endmodule

// File: tb/tb_dht_read_ctrl_060.sv
// Directed bench for dht_read_ctrl_060: a behavioural sensor answers the start pulse with
// hand-built frames; a second instance with auto-poll enabled and a silent line checks polling.
module tb_dht_read_ctrl_060;

    localparam int US = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_p = 1'b0;
    logic        sensor_low = 1'b0;
    wire         sda;
    wire         sda_p;
    logic        busy, valid, err;
    logic [39:0] raw;
    logic [3:0]  num1, num2, num3, num4, num5, num6, num7, num8;
    logic        busy_p, valid_p, err_p;
    logic [39:0] raw_p;
    logic [3:0]  nump1, nump2, nump3, nump4, nump5, nump6, nump7, nump8;
    wire  [31:0] digits = {num1, num2, num3, num4, num5, num6, num7, num8};

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          valid_cnt = 0;
    int          err_cnt = 0;

    pullup (sda);
    pullup (sda_p);
    assign sda = sensor_low ? 1'b0 : 1'bz;

    always #(US / 2) clk = ~clk;

    dht_read_ctrl_060 #(
        .CLK_FREQ_HZ(1_000_000), .POLL_MS(0), .START_LOW_MS(1), .TIMEOUT_US(200), .BIT_THRESH_US(50)
    ) dut (
        .I_clk(clk), .I_rst(rst), .I_start(start), .I_O_sda(sda),
        .O_busy(busy), .O_valid(valid), .O_err(err), .O_raw(raw),
        .O_num1(num1), .O_num2(num2), .O_num3(num3), .O_num4(num4),
        .O_num5(num5), .O_num6(num6), .O_num7(num7), .O_num8(num8)
    );

    dht_read_ctrl_060 #(
        .CLK_FREQ_HZ(1_000_000), .POLL_MS(3), .START_LOW_MS(1), .TIMEOUT_US(200), .BIT_THRESH_US(50)
    ) dut_poll (
        .I_clk(clk), .I_rst(rst), .I_start(start_p), .I_O_sda(sda_p),
        .O_busy(busy_p), .O_valid(valid_p), .O_err(err_p), .O_raw(raw_p),
        .O_num1(nump1), .O_num2(nump2), .O_num3(nump3), .O_num4(nump4),
        .O_num5(nump5), .O_num6(nump6), .O_num7(nump7), .O_num8(nump8)
    );

    // Pulse counters let the linear sequence see one-cycle strobes it would otherwise miss
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (valid === 1'b1) valid_cnt <= valid_cnt + 1;
        if (err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [39:0] frame, input int abort_bit);
        #(30 * US);
        sensor_low = 1'b1; #(80 * US);
        sensor_low = 1'b0; #(80 * US);
        for (int i = 39; i >= 0; i--) begin
            sensor_low = 1'b1; #(50 * US);
            sensor_low = 1'b0;
            if (39 - i == abort_bit) begin
                #(10 * US);
                return;
            end
            #((frame[i] ? 70 : 28) * US);
        end
        sensor_low = 1'b1; #(50 * US);
        sensor_low = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Host must pull the line low, then release it after the start pulse
    task automatic wait_host_release(output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        while (sda !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        if (sda !== 1'b0) return;
        n = 0;
        while (sda !== 1'b1 && n < 1500) begin @(negedge clk); n++; end
        ok = (sda === 1'b1);
    endtask

    task automatic read_frame(input string tag, input logic [39:0] frame, input int abort_bit);
        bit ok;
        pulse_start();
        wait_host_release(ok);
        check_output({tag, "_host_start"}, 64'(ok), 64'(1));
        if (ok) apply_stimulus(frame, abort_bit);
    endtask

    task automatic wait_poll_rise(output int unsigned t, output bit ok);
        logic prev;
        prev = busy_p;
        ok = 1'b0;
        t = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (busy_p && !prev) begin
                t = cyc;
                ok = 1'b1;
                return;
            end
            prev = busy_p;
        end
    endtask

    initial begin
        int          v0, e0;
        int unsigned r_cyc, e_cyc, t0, t1, t2;
        bit          ok, low_seen;

        // Reset state
        repeat (3) @(negedge clk);
        check_output("rst_busy", 64'(busy), 64'(0));
        check_output("rst_valid_err", 64'({valid, err}), 64'(0));
        check_output("rst_raw", 64'(raw), 64'(0));
        check_output("rst_digits", 64'(digits), 64'(0));
        check_output("rst_sda_released", 64'(sda), 64'(1));
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Good frame 60.0 %, 25.5 C
        v0 = valid_cnt; e0 = err_cnt;
        read_frame("t1", 40'h3C0019055A, -1);
        repeat (20) @(negedge clk);
        check_output("t1_valid_once", 64'(valid_cnt - v0), 64'(1));
        check_output("t1_no_err", 64'(err_cnt - e0), 64'(0));
        check_output("t1_raw", 64'(raw), 64'h3C0019055A);
        check_output("t1_digits", 64'(digits), 64'h60002505);
        check_output("t1_busy", 64'(busy), 64'(0));

        // Bad checksum: error pulse, published values untouched
        v0 = valid_cnt; e0 = err_cnt;
        read_frame("t2", 40'h3C0019055B, -1);
        repeat (20) @(negedge clk);
        check_output("t2_err_once", 64'(err_cnt - e0), 64'(1));
        check_output("t2_no_valid", 64'(valid_cnt - v0), 64'(0));
        check_output("t2_raw_hold", 64'(raw), 64'h3C0019055A);
        check_output("t2_digits_hold", 64'(digits), 64'h60002505);
        check_output("t2_busy", 64'(busy), 64'(0));

        // Humidity 100 saturates to 99
        v0 = valid_cnt;
        read_frame("t6a", 40'h6400190582, -1);
        repeat (20) @(negedge clk);
        check_output("t6a_valid", 64'(valid_cnt - v0), 64'(1));
        check_output("t6a_raw", 64'(raw), 64'h6400190582);
        check_output("t6a_digits", 64'(digits), 64'h99002505);

        // Checksum wraps: 0xFF + 0x02 = 0x01
        v0 = valid_cnt;
        read_frame("t6b", 40'hFF00020001, -1);
        repeat (20) @(negedge clk);
        check_output("t6b_valid", 64'(valid_cnt - v0), 64'(1));
        check_output("t6b_raw", 64'(raw), 64'hFF00020001);
        check_output("t6b_digits", 64'(digits), 64'h99000200);

        // Silent sensor: error exactly 200 us after the line is released
        v0 = valid_cnt;
        pulse_start();
        wait_host_release(ok);
        check_output("t3_host_start", 64'(ok), 64'(1));
        r_cyc = cyc;
        e_cyc = 0;
        low_seen = 1'b0;
        for (int n = 0; n < 400 && e_cyc == 0; n++) begin
            @(negedge clk);
            if (sda !== 1'b1) low_seen = 1'b1;
            if (err === 1'b1) begin
                e_cyc = cyc;
                check_output("t3_busy_at_err", 64'(busy), 64'(0));
            end
        end
        check_output("t3_timeout_cycles", 64'(e_cyc - r_cyc), 64'(200));
        check_output("t3_sda_released", 64'(low_seen), 64'(0));
        check_output("t3_raw_hold", 64'(raw), 64'hFF00020001);
        check_output("t3_no_valid", 64'(valid_cnt - v0), 64'(0));
        repeat (10) @(negedge clk);

        // Reset in the middle of bit 17 clears everything immediately
        v0 = valid_cnt; e0 = err_cnt;
        read_frame("t4", 40'h3C0019055A, 17);
        check_output("t4_busy_before", 64'(busy), 64'(1));
        #(US / 5);
        rst = 1'b1;
        #1;
        check_output("t4_busy", 64'(busy), 64'(0));
        check_output("t4_raw", 64'(raw), 64'(0));
        check_output("t4_digits", 64'(digits), 64'(0));
        check_output("t4_sda", 64'(sda), 64'(1));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_output("t4_no_pulses", 64'({valid_cnt - v0, err_cnt - e0}), 64'(0));
        v0 = valid_cnt;
        read_frame("t4b", 40'h3C0019055A, -1);
        repeat (20) @(negedge clk);
        check_output("t4b_valid", 64'(valid_cnt - v0), 64'(1));
        check_output("t4b_raw", 64'(raw), 64'h3C0019055A);
        check_output("t4b_digits", 64'(digits), 64'h60002505);

        // Auto-poll every 3 ms (plus tick pipeline); a start while busy is dropped
        wait_poll_rise(t0, ok);
        check_output("t5_first_poll", 64'(ok), 64'(1));
        wait_poll_rise(t1, ok);
        check_output("t5_period", 64'((t1 - t0) >= 3000 && (t1 - t0) <= 3006), 64'(1));
        repeat (100) @(negedge clk);
        check_output("t5_busy_when_start", 64'(busy_p), 64'(1));
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        wait_poll_rise(t2, ok);
        check_output("t5_start_ignored", 64'((t2 - t1) >= 3000 && (t2 - t1) <= 3006), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
